// File: rtl/controlador_quadro.sv
// controlador_quadro
// Frame controller for the edge-detection coprocessor. A rising edge on
// start launches one frame: the coprocessor is enabled, it reads the source
// RAM and writes the result RAM through this block, and the frame ends when
// it raises cop_acabou. A watchdog aborts a frame that runs too long. A done
// flag that is already high at launch also aborts the frame.
//
// Handshake: there is no valid/ready pair on this block. A request is a
// rising edge of start, and only IDLE or PRONTO accept it. cop_acabou is a
// level that the first PROCESSA cycle which sees it high consumes. The
// result-RAM write port (res_wren/res_wraddress/res_data) is a one-cycle-
// delayed copy of the coprocessor write strobe. It is gated by the frame
// being active.
//
// Ports
//   clock_50MHz      system clock, rising edge
//   reset_n          asynchronous active-low reset
//   start            frame request (level, rising edge used)
//   clear_err        leaves ERRO when high
//   cop_rdaddress    coprocessor source read address
//   cop_wraddress    coprocessor result write address
//   cop_pixel        coprocessor result pixel
//   cop_enable       coprocessor write strobe
//   cop_acabou       coprocessor frame-done level
//   vga_rdaddress    scan-out read address
//   cop_enable_start run enable to the coprocessor (PROCESSA only)
//   src_rdaddress    source RAM read address (muxed)
//   res_wraddress    result RAM write address (registered)
//   res_data         result RAM write data (registered)
//   res_wren         result RAM write enable (registered)
//   vga_sel          1 when scan-out owns the source RAM address
//   ocupado          frame in progress
//   pronto           one-cycle frame-complete pulse
//   erro             in ERRO state
//   err_code         01 = done already high at start, 10 = watchdog timeout
//   frame_count      completed frames, modulo 256
//   estado           current FSM state (IDLE=0 PROCESSA=1 PRONTO=2 ERRO=4)
module controlador_quadro #(
  parameter logic [19:0] TIMEOUT = 20'd200000
) (
  input  logic        clock_50MHz,
  input  logic        reset_n,
  input  logic        start,
  input  logic        clear_err,
  input  logic [11:0] cop_rdaddress,
  input  logic [11:0] cop_wraddress,
  input  logic        cop_pixel,
  input  logic        cop_enable,
  input  logic        cop_acabou,
  input  logic [11:0] vga_rdaddress,
  output logic        cop_enable_start,
  output logic [11:0] src_rdaddress,
  output logic [11:0] res_wraddress,
  output logic        res_data,
  output logic        res_wren,
  output logic        vga_sel,
  output logic        ocupado,
  output logic        pronto,
  output logic        erro,
  output logic [1:0]  err_code,
  output logic [7:0]  frame_count,
  output logic [2:0]  estado
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PROCESSA = 3'd1,
    ST_PRONTO   = 3'd2,
    ST_ERRO     = 3'd4
  } state_t;

  localparam logic [19:0] WD_LIMIT = TIMEOUT - 20'd1;

  state_t      state;
  state_t      state_next;
  logic        start_q;
  logic        start_edge;
  logic [19:0] watchdog;
  logic        done;
  logic        err_set;
  logic [1:0]  err_val;

  // The edge is used combinationally so it is acted on in the cycle it is seen.
  assign start_edge = start & ~start_q;

  always_comb begin
    state_next = state;
    done       = 1'b0;
    err_set    = 1'b0;
    err_val    = 2'b00;
    case (state)
      ST_IDLE, ST_PRONTO: begin
        if (start_edge) begin
          if (cop_acabou) begin
            // Done still high from the last frame: the coprocessor was not re-armed.
            state_next = ST_ERRO;
            err_set    = 1'b1;
            err_val    = 2'b01;
          end else begin
            state_next = ST_PROCESSA;
          end
        end
      end
      ST_PROCESSA: begin
        // Completion is checked first so that it wins over a same-cycle timeout.
        if (cop_acabou) begin
          state_next = ST_PRONTO;
          done       = 1'b1;
        end else if (watchdog == WD_LIMIT) begin
          state_next = ST_ERRO;
          err_set    = 1'b1;
          err_val    = 2'b10;
        end
      end
      ST_ERRO: begin
        if (clear_err) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      start_q     <= 1'b0;
      watchdog    <= 20'd0;
      pronto      <= 1'b0;
      frame_count <= 8'd0;
      err_code    <= 2'b00;
    end else begin
      state       <= state_next;
      start_q     <= start;
      // The watchdog is zero outside PROCESSA, so every accepted frame starts from 0.
      watchdog    <= (state == ST_PROCESSA) ? watchdog + 20'd1 : 20'd0;
      pronto      <= done;
      frame_count <= frame_count + {7'd0, done};
      if (err_set) begin
        err_code <= err_val;
      end else if (state == ST_ERRO && clear_err) begin
        err_code <= 2'b00;
      end
    end
  end

  // Result RAM write port: one cycle behind the coprocessor. The write from
  // the last PROCESSA cycle is dropped when that cycle exits to ERRO.
  always_ff @(posedge clock_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      res_wren      <= 1'b0;
      res_wraddress <= 12'd0;
      res_data      <= 1'b0;
    end else begin
      res_wren      <= (state == ST_PROCESSA) && cop_enable && (state_next != ST_ERRO);
      res_wraddress <= cop_wraddress;
      res_data      <= cop_pixel;
    end
  end

  assign estado           = state;
  assign cop_enable_start = (state == ST_PROCESSA);
  assign ocupado          = (state == ST_PROCESSA);
  assign erro             = (state == ST_ERRO);
  assign vga_sel          = (state != ST_PROCESSA);
  assign src_rdaddress    = (state == ST_PROCESSA) ? cop_rdaddress : vga_rdaddress;

endmodule

// File: doc/controlador_quadro.md
CONTROLADOR_QUADRO -- requirements
Module: controlador_quadro

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 20'd200000, the watchdog limit in clock cycles for one frame.
REQ-002 The block SHALL have port clock_50MHz  in  1  the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port start  in  1  frame request, level; only its rising edge is used.
REQ-005 The block SHALL have port clear_err  in  1  leaves ERRO, level, sampled each cycle.
REQ-006 The block SHALL have ports cop_rdaddress  in  12, cop_wraddress  in  12, cop_pixel  in  1, cop_enable  in  1 and cop_acabou  in  1, all driven by the edge coprocessor.
REQ-007 The block SHALL have port vga_rdaddress  in  12  scan-out read address.
REQ-008 The block SHALL have port cop_enable_start  out  1  run enable to the coprocessor.
REQ-009 The block SHALL have port src_rdaddress  out  12  read address of the source-image RAM.
REQ-010 The block SHALL have ports res_wraddress  out  12, res_data  out  1 and res_wren  out  1, the write port of the result RAM.
REQ-011 The block SHALL have port vga_sel  out  1  meaning 1 when vga_rdaddress owns src_rdaddress.
REQ-012 The block SHALL have ports ocupado  out  1, pronto  out  1, erro  out  1, err_code  out  2, frame_count  out  8 and estado  out  3.

Function
REQ-013 The block SHALL implement states IDLE=0, PROCESSA=1, PRONTO=2 and ERRO=4; estado SHALL equal the current state.
REQ-014 The block SHALL detect a start rising edge using a registered copy of start; the edge SHALL be acted on in the same cycle it is detected.
REQ-015 In IDLE or PRONTO, a start edge SHALL move the block to PROCESSA on the next edge. The block SHALL clear the watchdog and assert cop_enable_start=1 and ocupado=1 from the next cycle.
REQ-016 A start edge in PROCESSA or ERRO SHALL be ignored and SHALL NOT restart the watchdog.
REQ-017 If cop_acabou=1 in the cycle a start edge is accepted, the block SHALL go to ERRO with err_code=2'b01 (coprocessor not re-armed) instead of PROCESSA.
REQ-018 In PROCESSA, a 20-bit watchdog SHALL increment every cycle. Reaching TIMEOUT-1 SHALL cause the block to enter ERRO with err_code=2'b10.
REQ-019 In PROCESSA, the first cycle with cop_acabou=1 SHALL cause the block to enter PRONTO. It SHALL pulse pronto for exactly one cycle and increment frame_count modulo 256 (255->0).
REQ-020 If cop_acabou=1 and the watchdog limit occur in the same cycle, completion (PRONTO) SHALL win.
REQ-021 cop_enable_start SHALL be 1 only in PROCESSA; ocupado SHALL equal (estado==PROCESSA).
REQ-022 src_rdaddress SHALL be combinationally cop_rdaddress in PROCESSA and vga_rdaddress otherwise. vga_sel SHALL be 0 in PROCESSA and 1 otherwise.
REQ-023 res_wren SHALL be a registered copy of (estado==PROCESSA && cop_enable==1), with one-cycle latency. res_wraddress and res_data SHALL be cop_wraddress and cop_pixel registered in the same cycle.
REQ-024 res_wren SHALL never be 1 while estado is IDLE, PRONTO or ERRO, except for the single trailing cycle after leaving PROCESSA.
REQ-025 The write of REQ-024's trailing cycle SHALL be suppressed if the exit was to ERRO.
REQ-026 erro SHALL be 1 exactly while in ERRO. err_code SHALL hold its value until clear_err or reset.
REQ-027 clear_err=1 in ERRO SHALL cause the block to enter IDLE and zero err_code. clear_err SHALL be ignored in other states.
REQ-028 frame_count SHALL NOT change on error paths.

Reset
REQ-029 reset_n=0 SHALL immediately, without waiting for a clock, force: estado=IDLE; cop_enable_start=0; res_wren=0; res_wraddress=0; res_data=0; ocupado=0; pronto=0; erro=0; err_code=0; frame_count=0; watchdog=0; start history=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame, with no further res_wren. After release, a fresh start edge SHALL be required.

Verification
REQ-031 The bench SHALL cover a nominal frame: start 0->1 in IDLE, then cop_enable pulses, then cop_acabou=1 at cycle 5000. Required response: PRONTO, one-cycle pronto, frame_count=1, res_wren mirroring cop_enable delayed by 1 cycle.
REQ-032 The bench SHALL cover a timeout: TIMEOUT=100 with cop_acabou held 0. Required response: ERRO after exactly 100 PROCESSA cycles, err_code=2'b10, then clear_err -> IDLE with err_code=0.
REQ-033 The bench SHALL cover a stale done: cop_acabou=1 at the start edge. Required response: ERRO with err_code=2'b01, cop_enable_start never 1.
REQ-034 The bench SHALL cover the mux: vga_rdaddress=12'h0AB and cop_rdaddress=12'h041. Required response: src_rdaddress=0AB in IDLE/PRONTO and 041 in PROCESSA.
REQ-035 The bench SHALL cover a simultaneous event: cop_acabou rises on the TIMEOUT-1 cycle. Required response: PRONTO, erro=0.
REQ-036 The bench SHALL cover wrap and reset: 256 frames give frame_count=0. reset_n low mid-PROCESSA SHALL give all outputs at reset values before the next clock edge.
